// File: rtl/open_list_pkg.sv
`default_nettype none
// ============================================================================
// open_list_pkg : shared types and defaults for the A* open-list store.
// Revision: 1.0
// ============================================================================
package open_list_pkg;

    localparam int OL_COORD_W = 8;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'b00,
        OP_APPEND = 2'b01,
        OP_REMOVE = 2'b10,
        OP_CLEAR  = 2'b11
    } ol_op_e;

    // ST_APND is only reachable when APPEND carries a duplicate check.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_RESP = 2'b10,
        ST_APND = 2'b11
    } ol_state_e;

endpackage : open_list_pkg
`default_nettype wire

// File: rtl/open_list_lane_cmp.sv
`default_nettype none
// ============================================================================
// open_list_lane_cmp : masked LANES-wide key compare with lowest-hit encode.
// Revision: 1.0
// ============================================================================
module open_list_lane_cmp
    import open_list_pkg::*;
#(
    parameter int COORD_W = OL_COORD_W,
    parameter int LANES   = 4,
    parameter int CNT_W   = 10,
    localparam int OFF_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [COORD_W-1:0] ent_x_i [LANES],
    input  logic [COORD_W-1:0] ent_y_i [LANES],
    input  logic [COORD_W-1:0] key_x_i,
    input  logic [COORD_W-1:0] key_y_i,
    input  logic [CNT_W-1:0]   base_i,
    input  logic [CNT_W-1:0]   count_i,
    output logic               hit_o,
    output logic [OFF_W-1:0]   hit_off_o
);

    logic [LANES-1:0] w_match;

    for (genvar l = 0; l < LANES; l++) begin : g_cmp
        assign w_match[l] = ((base_i + CNT_W'(l)) < count_i) &&
                            (ent_x_i[l] == key_x_i) && (ent_y_i[l] == key_y_i);
    end

    always_comb begin
        hit_off_o = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (w_match[l]) begin
                hit_off_o = OFF_W'(l);
            end
        end
    end

    assign hit_o = |w_match;

endmodule : open_list_lane_cmp
`default_nettype wire

// File: rtl/open_list_search.sv
`default_nettype none
// ============================================================================
// open_list_search : open-list coordinate store with lane-parallel SEARCH,
//   APPEND, REMOVE, CLEAR. Define OPEN_LIST_DUPCHK_EN for duplicate-checked APPEND.
// Revision: 1.0
// ============================================================================
module open_list_search
    import open_list_pkg::*;
#(
    parameter int COORD_W = OL_COORD_W,
    parameter int DEPTH   = 400,
    parameter int LANES   = 4,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [COORD_W-1:0] cmd_x_i,
    input  logic [COORD_W-1:0] cmd_y_i,
    input  logic [IDX_W-1:0]   cmd_idx_i,
    output logic               rsp_valid_o,
    output logic               rsp_found_o,
    output logic [IDX_W-1:0]   rsp_idx_o,
    output logic               rsp_err_o,
    output logic [IDX_W:0]     count_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1;

    ol_state_e            state_q;
    ol_op_e               op_q;
    logic [COORD_W-1:0]   key_x_q, key_y_q;
    logic [CNT_W-1:0]     count_q, base_q;
    logic                 rsp_valid_q, rsp_found_q, rsp_err_q;
    logic [IDX_W-1:0]     rsp_idx_q;
    logic [COORD_W-1:0]   mem_x_q [DEPTH];
    logic [COORD_W-1:0]   mem_y_q [DEPTH];

    ol_op_e               w_op;
    logic                 w_empty, w_full, w_app_now, w_rm_ok, w_rm_move, w_scan_done;
    logic [IDX_W-1:0]     w_last_idx, w_hit_idx;
    logic [COORD_W-1:0]   w_lane_x [LANES];
    logic [COORD_W-1:0]   w_lane_y [LANES];
    logic                 w_hit;
    logic [OFF_W-1:0]     w_hit_off;
    logic                 w_wr_en;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [COORD_W-1:0]   w_wr_x, w_wr_y;

    assign w_op        = ol_op_e'(cmd_op_i);
    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == CNT_W'(DEPTH));
    assign w_last_idx  = w_empty ? '0 : IDX_W'(count_q - CNT_W'(1));
    assign w_rm_ok     = (CNT_W'(cmd_idx_i) < count_q);
    assign w_rm_move   = ((CNT_W'(cmd_idx_i) + CNT_W'(1)) < count_q);
    assign w_scan_done = ((int'(base_q) + LANES) >= int'(count_q));
    assign w_hit_idx   = IDX_W'(base_q + CNT_W'(w_hit_off));

`ifdef OPEN_LIST_DUPCHK_EN
    // An empty list cannot hold a duplicate, so skip the scan.
    assign w_app_now = w_empty;
`else
    assign w_app_now = 1'b1;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CNT_W-1:0] w_addr;
        assign w_addr      = base_q + CNT_W'(l);
        assign w_lane_x[l] = (w_addr < CNT_W'(DEPTH)) ? mem_x_q[w_addr[IDX_W-1:0]] : '0;
        assign w_lane_y[l] = (w_addr < CNT_W'(DEPTH)) ? mem_y_q[w_addr[IDX_W-1:0]] : '0;
    end

    open_list_lane_cmp #(
        .COORD_W (COORD_W),
        .LANES   (LANES),
        .CNT_W   (CNT_W)
    ) u_lane_cmp (
        .ent_x_i   (w_lane_x),
        .ent_y_i   (w_lane_y),
        .key_x_i   (key_x_q),
        .key_y_i   (key_y_q),
        .base_i    (base_q),
        .count_i   (count_q),
        .hit_o     (w_hit),
        .hit_off_o (w_hit_off)
    );

    // REMOVE back-fills the hole with the last entry to keep storage dense.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        w_wr_x   = '0;
        w_wr_y   = '0;
        if (state_q == ST_IDLE && cmd_valid_i) begin
            if (w_op == OP_APPEND && w_app_now && !w_full) begin
                w_wr_en  = 1'b1;
                w_wr_idx = IDX_W'(count_q);
                w_wr_x   = cmd_x_i;
                w_wr_y   = cmd_y_i;
            end else if (w_op == OP_REMOVE && w_rm_move) begin
                w_wr_en  = 1'b1;
                w_wr_idx = cmd_idx_i;
                w_wr_x   = mem_x_q[w_last_idx];
                w_wr_y   = mem_y_q[w_last_idx];
            end
        end else if (state_q == ST_APND && !w_full) begin
            w_wr_en  = 1'b1;
            w_wr_idx = IDX_W'(count_q);
            w_wr_x   = key_x_q;
            w_wr_y   = key_y_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            mem_x_q[w_wr_idx] <= w_wr_x;
            mem_y_q[w_wr_idx] <= w_wr_y;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SEARCH;
            key_x_q     <= '0;
            key_y_q     <= '0;
            count_q     <= '0;
            base_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q    <= w_op;
                        key_x_q <= cmd_x_i;
                        key_y_q <= cmd_y_i;
                        base_q  <= '0;
                        case (w_op)
                            OP_SEARCH: begin
                                if (w_empty) begin
                                    state_q     <= ST_RESP;
                                    rsp_valid_q <= 1'b1;
                                    rsp_found_q <= 1'b0;
                                    rsp_idx_q   <= '0;
                                    rsp_err_q   <= 1'b0;
                                end else begin
                                    state_q <= ST_SCAN;
                                end
                            end
                            OP_APPEND: begin
                                if (w_app_now) begin
                                    state_q     <= ST_RESP;
                                    rsp_valid_q <= 1'b1;
                                    rsp_found_q <= 1'b0;
                                    rsp_idx_q   <= IDX_W'(count_q);
                                    rsp_err_q   <= w_full;
                                    if (!w_full) count_q <= count_q + CNT_W'(1);
                                end else begin
                                    state_q <= ST_SCAN;
                                end
                            end
                            OP_REMOVE: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_found_q <= 1'b0;
                                rsp_idx_q   <= cmd_idx_i;
                                rsp_err_q   <= !w_rm_ok;
                                if (w_rm_ok) count_q <= count_q - CNT_W'(1);
                            end
                            default: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_found_q <= 1'b0;
                                rsp_idx_q   <= '0;
                                rsp_err_q   <= 1'b0;
                                count_q     <= '0;
                            end
                        endcase
                    end
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_found_q <= 1'b1;
                        rsp_idx_q   <= w_hit_idx;
                        rsp_err_q   <= 1'b0;
                    end else if (w_scan_done) begin
                        if (op_q == OP_APPEND) begin
                            state_q <= ST_APND;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_found_q <= 1'b0;
                            rsp_idx_q   <= '0;
                            rsp_err_q   <= 1'b0;
                        end
                    end else begin
                        base_q <= base_q + CNT_W'(LANES);
                    end
                end
                ST_APND: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_found_q <= 1'b0;
                    rsp_idx_q   <= IDX_W'(count_q);
                    rsp_err_q   <= w_full;
                    if (!w_full) count_q <= count_q + CNT_W'(1);
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_found_o = rsp_found_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_err_o   = rsp_err_q;
    assign count_o     = count_q;
    assign empty_o     = w_empty;
    assign full_o      = w_full;

endmodule : open_list_search
`default_nettype wire
